// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the SPI memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // SPI command bytes understood by both the flash and the RAM
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    // Operation requested by ctrl
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_ctrl_op_e;

    // Address source: PC addresses program flash, MAR addresses data RAM
    typedef enum logic {
        ADDR_PC  = 1'b0,
        ADDR_MAR = 1'b1
    } addr_sel_e;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_REARM = 2'd3
    } mem_ctrl_state_e;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_spi_shifter
// Purpose  : SPI mode-0 frame engine. Shifts a preloaded frame out MSB first
//            at clock/2 and collects the last RX_W bits seen on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_spi_shifter #(
    parameter int BITS = 40,
    parameter int RX_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] frame,
    input  logic            miso,
    output logic            sck,
    output logic            mosi,
    output logic            last,
    output logic [RX_W-1:0] rx_next
);

    localparam int CNT_W = $clog2(BITS);

    logic [BITS-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic            active;
    logic [RX_W-1:0] rx;

    // sck doubles as the phase flag: high phase is the final cycle of a bit
    assign last    = active && sck && (bit_cnt == CNT_W'(BITS - 1));
    // Byte as it will look once the MISO bit of this cycle is captured
    assign rx_next = {rx[RX_W-2:0], miso};

    // Bit engine: low phase presents MOSI, high phase raises SCK and samples MISO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            rx      <= '0;
        end else if (start) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            sck     <= 1'b0;
            mosi    <= frame[BITS-1];
            shreg   <= {frame[BITS-2:0], 1'b0};
        end else if (active) begin
            if (!sck) begin
                sck <= 1'b1;
            end else begin
                rx  <= rx_next;
                sck <= 1'b0;
                if (bit_cnt == CNT_W'(BITS - 1)) begin
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    mosi    <= shreg[BITS-1];
                    shreg   <= {shreg[BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule : mem_ctrl_spi_shifter
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Serves one byte per request from SPI flash (PC) or SPI RAM (MAR).
//            Owns request latching, chip-select decode and the done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int SPI_ADDR_BYTES = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  addr_sel_e                 addr_sel,
    input  logic [ADDR_WIDTH-1:0]     addr_in,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_cs_flash_n,
    output logic                      spi_cs_ram_n
);

    localparam int ADDR_BITS = 8 * SPI_ADDR_BYTES;
    localparam int BITS      = 8 + ADDR_BITS + DATA_BUS_WIDTH;

    mem_ctrl_state_e           state;
    logic                      is_read;
    logic                      flash_write;
    logic                      start;
    logic                      last;
    logic [ADDR_BITS-1:0]      addr_ext;
    logic [7:0]                cmd;
    logic [DATA_BUS_WIDTH-1:0] payload;
    logic [BITS-1:0]           frame;
    logic [DATA_BUS_WIDTH-1:0] rx_next;

    // Writing program flash is not allowed; such a request completes without SPI traffic
    assign flash_write = (mem_ctrl_op == MEM_WRITE) && (addr_sel == ADDR_PC);
    assign start       = (state == ST_IDLE) && (mem_ctrl_op != MEM_NOP) && !flash_write;

    // The frame is captured by the shifter on the start edge, which latches addr/data
    assign addr_ext = ADDR_BITS'(addr_in);
    assign cmd      = (mem_ctrl_op == MEM_READ) ? SPI_CMD_READ : SPI_CMD_WRITE;
    assign payload  = (mem_ctrl_op == MEM_WRITE) ? data_in : '0;
    assign frame    = {cmd, addr_ext, payload};

    mem_ctrl_spi_shifter #(
        .BITS (BITS),
        .RX_W (DATA_BUS_WIDTH)
    ) u_shifter (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .frame   (frame),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .last    (last),
        .rx_next (rx_next)
    );

    // Request FSM: latch on IDLE, wait for the frame, pulse done, then wait for NOP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            is_read        <= 1'b0;
            data_out       <= '0;
            mem_op_done    <= 1'b0;
            spi_cs_flash_n <= 1'b1;
            spi_cs_ram_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ctrl_op != MEM_NOP) begin
                        is_read <= (mem_ctrl_op == MEM_READ);
                        if (flash_write) begin
                            state       <= ST_DONE;
                            mem_op_done <= 1'b1;
                        end else begin
                            state          <= ST_SHIFT;
                            spi_cs_flash_n <= (addr_sel != ADDR_PC);
                            spi_cs_ram_n   <= (addr_sel != ADDR_MAR);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (last) begin
                        state          <= ST_DONE;
                        mem_op_done    <= 1'b1;
                        spi_cs_flash_n <= 1'b1;
                        spi_cs_ram_n   <= 1'b1;
                        if (is_read) begin
                            data_out <= rx_next;
                        end
                    end
                end
                ST_DONE: begin
                    mem_op_done <= 1'b0;
                    state       <= ST_REARM;
                end
                ST_REARM: begin
                    // ctrl may still hold the finished op; only a NOP re-arms
                    if (mem_ctrl_op == MEM_NOP) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a MISO byte model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic         clock;
    logic         reset;
    mem_ctrl_op_e mem_ctrl_op;
    addr_sel_e    addr_sel;
    logic [15:0]  addr_in;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic         mem_op_done;
    logic         spi_sck;
    logic         spi_mosi;
    logic         spi_miso;
    logic         spi_cs_flash_n;
    logic         spi_cs_ram_n;

    int total = 0;
    int bad   = 0;

    // SPI device model state
    logic [7:0]  miso_byte = 8'h00;
    logic [39:0] mosi_frame = '0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          flash_frames = 0;
    int          ram_frames = 0;

    mem_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .mem_ctrl_op    (mem_ctrl_op),
        .addr_sel       (addr_sel),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .mem_op_done    (mem_op_done),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_cs_flash_n (spi_cs_flash_n),
        .spi_cs_ram_n   (spi_cs_ram_n)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Device captures MOSI on rising SCK
    always @(posedge spi_sck) begin
        mosi_frame = {mosi_frame[38:0], spi_mosi};
        rise_cnt   = rise_cnt + 1;
    end

    // Device advances its output bit on falling SCK
    always @(negedge spi_sck) fall_cnt = fall_cnt + 1;

    always @(negedge spi_cs_flash_n) flash_frames = flash_frames + 1;
    always @(negedge spi_cs_ram_n)   ram_frames   = ram_frames + 1;

    // Data byte occupies frame bits 32..39; bit k is on the wire while fall_cnt==k
    always_comb begin
        spi_miso = 1'b0;
        if (fall_cnt >= 32 && fall_cnt < 40) spi_miso = miso_byte[39 - fall_cnt];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        mosi_frame = '0;
        rise_cnt   = 0;
        fall_cnt   = 0;
    endtask

    // Drives one request at cycle T, drops op afterwards, returns cycles to done
    task automatic run_op(input mem_ctrl_op_e op, input addr_sel_e sel,
                          input logic [15:0] a, input logic [7:0] d,
                          output int lat, output logic csf1, output logic csr1);
        mem_ctrl_op = op;
        addr_sel    = sel;
        addr_in     = a;
        data_in     = d;
        lat  = -1;
        csf1 = 1'bx;
        csr1 = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) begin
                csf1 = spi_cs_flash_n;
                csr1 = spi_cs_ram_n;
                mem_ctrl_op = MEM_NOP;
            end
            if (mem_op_done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic settle();
        mem_ctrl_op = MEM_NOP;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #12;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h want=00", data_out); end
        total++; if (mem_op_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", mem_op_done); end
        total++; if (spi_sck !== 1'b0 || spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_sck_mosi got=%b%b want=00", spi_sck, spi_mosi); end
        total++; if (spi_cs_flash_n !== 1'b1 || spi_cs_ram_n !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b%b want=11", spi_cs_flash_n, spi_cs_ram_n); end
        #10 reset = 1'b1;
        tick();
    endtask

    task automatic test_read_flash();
        int lat; logic cf, cr;
        clear_mon();
        miso_byte = 8'hA5;
        run_op(MEM_READ, ADDR_PC, 16'h0012, 8'hFF, lat, cf, cr);
        total++; if (cf !== 1'b0 || cr !== 1'b1) begin bad++; $display("FAIL rd_cs got=%b%b want=01", cf, cr); end
        total++; if (lat !== 81) begin bad++; $display("FAIL rd_latency got=%0d want=81", lat); end
        total++; if (mosi_frame !== 40'h0300001200) begin bad++; $display("FAIL rd_frame got=%h want=0300001200", mosi_frame); end
        total++; if (rise_cnt !== 40) begin bad++; $display("FAIL rd_bits got=%0d want=40", rise_cnt); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h want=a5", data_out); end
        total++; if (spi_sck !== 1'b0 || spi_cs_flash_n !== 1'b1 || spi_cs_ram_n !== 1'b1) begin
            bad++; $display("FAIL rd_done_idle_pins got=%b%b%b want=011", spi_sck, spi_cs_flash_n, spi_cs_ram_n); end
        tick();
        total++; if (mem_op_done !== 1'b0) begin bad++; $display("FAIL rd_done_width got=%b want=0", mem_op_done); end
        settle();
    endtask

    task automatic test_write_ram();
        int lat; logic cf, cr;
        clear_mon();
        miso_byte = 8'h3C;
        run_op(MEM_WRITE, ADDR_MAR, 16'h1234, 8'h5C, lat, cf, cr);
        total++; if (cf !== 1'b1 || cr !== 1'b0) begin bad++; $display("FAIL wr_cs got=%b%b want=10", cf, cr); end
        total++; if (lat !== 81) begin bad++; $display("FAIL wr_latency got=%0d want=81", lat); end
        total++; if (mosi_frame !== 40'h020012345C) begin bad++; $display("FAIL wr_frame got=%h want=020012345c", mosi_frame); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL wr_data_kept got=%h want=a5", data_out); end
        settle();
    endtask

    task automatic test_flash_write();
        int lat; logic cf, cr; int ff, rf;
        clear_mon();
        ff = flash_frames; rf = ram_frames;
        run_op(MEM_WRITE, ADDR_PC, 16'h0100, 8'h99, lat, cf, cr);
        total++; if (lat !== 1) begin bad++; $display("FAIL fw_latency got=%0d want=1", lat); end
        total++; if (cf !== 1'b1 || cr !== 1'b1) begin bad++; $display("FAIL fw_cs got=%b%b want=11", cf, cr); end
        settle();
        total++; if (rise_cnt !== 0 || flash_frames !== ff || ram_frames !== rf) begin
            bad++; $display("FAIL fw_no_spi got=rises %0d frames %0d/%0d want=0 %0d/%0d", rise_cnt, flash_frames, ram_frames, ff, rf); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL fw_data_kept got=%h want=a5", data_out); end
    endtask

    task automatic test_back_to_back();
        int lat; logic cf, cr; int rf;
        clear_mon();
        rf = ram_frames;
        miso_byte = 8'h77;
        mem_ctrl_op = MEM_READ; addr_sel = ADDR_MAR; addr_in = 16'h0040; data_in = 8'h00;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (mem_op_done === 1'b1) begin lat = n; break; end
        end
        total++; if (lat !== 81) begin bad++; $display("FAIL b2b_first_latency got=%0d want=81", lat); end
        total++; if (data_out !== 8'h77) begin bad++; $display("FAIL b2b_first_data got=%h want=77", data_out); end
        tick();          // op still held in the cycle after done
        tick();
        mem_ctrl_op = MEM_NOP;
        total++; if (spi_cs_ram_n !== 1'b1 || rise_cnt !== 40) begin
            bad++; $display("FAIL b2b_no_restart got=cs %b rises %0d want=cs 1 rises 40", spi_cs_ram_n, rise_cnt); end
        tick();
        clear_mon();
        miso_byte = 8'h81;
        run_op(MEM_READ, ADDR_MAR, 16'h0041, 8'h00, lat, cf, cr);
        total++; if (lat !== 81 || cr !== 1'b0) begin bad++; $display("FAIL b2b_second got=lat %0d cs %b want=lat 81 cs 0", lat, cr); end
        total++; if (mosi_frame !== 40'h0300004100) begin bad++; $display("FAIL b2b_frame got=%h want=0300004100", mosi_frame); end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL b2b_second_data got=%h want=81", data_out); end
        total++; if (ram_frames - rf !== 2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", ram_frames - rf); end
        settle();
    endtask

    task automatic test_reset_mid_frame();
        int lat; logic cf, cr;
        mem_ctrl_op = MEM_READ; addr_sel = ADDR_PC; addr_in = 16'h0050; data_in = 8'h00;
        tick();
        mem_ctrl_op = MEM_NOP;
        repeat (24) tick();     // well inside the address bytes
        total++; if (spi_cs_flash_n !== 1'b0) begin bad++; $display("FAIL rst_mid_active got=%b want=0", spi_cs_flash_n); end
        #2 reset = 1'b0;
        #1;
        total++; if (spi_cs_flash_n !== 1'b1 || spi_cs_ram_n !== 1'b1 || spi_sck !== 1'b0) begin
            bad++; $display("FAIL rst_mid_pins got=%b%b%b want=110", spi_cs_flash_n, spi_cs_ram_n, spi_sck); end
        total++; if (mem_op_done !== 1'b0 || data_out !== 8'h00) begin
            bad++; $display("FAIL rst_mid_outputs got=%b %h want=0 00", mem_op_done, data_out); end
        #2 reset = 1'b1;
        tick();
        clear_mon();
        miso_byte = 8'h3E;
        run_op(MEM_READ, ADDR_PC, 16'h0003, 8'h00, lat, cf, cr);
        total++; if (lat !== 81 || cf !== 1'b0) begin bad++; $display("FAIL rst_next_read got=lat %0d cs %b want=lat 81 cs 0", lat, cf); end
        total++; if (mosi_frame !== 40'h0300000300 || rise_cnt !== 40) begin
            bad++; $display("FAIL rst_next_frame got=%h/%0d want=0300000300/40", mosi_frame, rise_cnt); end
        total++; if (data_out !== 8'h3E) begin bad++; $display("FAIL rst_next_data got=%h want=3e", data_out); end
        settle();
    endtask

    task automatic test_input_changes();
        int lat; int ff, rf;
        clear_mon();
        ff = flash_frames; rf = ram_frames;
        miso_byte = 8'hC3;
        mem_ctrl_op = MEM_WRITE; addr_sel = ADDR_MAR; addr_in = 16'h0A0B; data_in = 8'hD2;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) begin
                mem_ctrl_op = MEM_READ; addr_sel = ADDR_PC; addr_in = 16'hFFFF; data_in = 8'h11;
            end
            if (n == 60) mem_ctrl_op = MEM_NOP;
            if (mem_op_done === 1'b1) begin lat = n; break; end
        end
        total++; if (lat !== 81) begin bad++; $display("FAIL chg_latency got=%0d want=81", lat); end
        total++; if (mosi_frame !== 40'h02000A0BD2) begin bad++; $display("FAIL chg_frame got=%h want=02000a0bd2", mosi_frame); end
        total++; if (flash_frames !== ff || ram_frames - rf !== 1) begin
            bad++; $display("FAIL chg_cs got=flash %0d ram %0d want=flash 0 ram 1", flash_frames - ff, ram_frames - rf); end
        total++; if (data_out !== 8'h3E) begin bad++; $display("FAIL chg_data_kept got=%h want=3e", data_out); end
        settle();
    endtask

    initial begin
        reset       = 1'b0;
        mem_ctrl_op = MEM_NOP;
        addr_sel    = ADDR_PC;
        addr_in     = '0;
        data_in     = '0;
        test_reset();
        test_read_flash();
        test_write_ram();
        test_flash_write();
        test_back_to_back();
        test_reset_mid_frame();
        test_input_changes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
